mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit for the MEM stage of the RISC-V core. Consumes the memory-related control fields produced by the instruction decoder (MemRead, LoadType, MemWrite, StoreType), plus the ALU-computed address and rs2 data. Runs a request/acknowledge transaction on the data bus with byte-lane steering, sign/zero extension and a bus timeout, and stalls the pipeline while the access is in flight.

## Interface
- TIMEOUT, 255: maximum BUSY cycles to wait for `bus_ack` before aborting (≥1).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  MemRead from the decoder.
- load_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_write  in  1  MemWrite from the decoder.
- store_type  in  3  funct3: 000 SB, 001 SH, 010 SW.
- addr  in  32  effective byte address.
- wdata  in  32  store data (rs2).
- flush  in  1  squash the current MEM-stage instruction.
- stall  out  1  hold the pipeline (combinational).
- rdata  out  32  formatted load result (registered).
- rdata_valid  out  1  load result valid; one cycle.
- misalign  out  1  misaligned access detected; combinational, no bus traffic.
- access_fault  out  1  illegal funct3 (combinational) or bus timeout (registered, RESP cycle).
- bus_req, bus_we  out  1  request / write strobe (registered).
- bus_addr  out  32  `{addr[31:2], 2'b00}` (registered).
- bus_be  out  4  byte enables (registered).
- bus_wdata  out  32  lane-replicated store data (registered).
- bus_ack  in  1  slave completion; sampled only in BUSY.
- bus_rdata  in  32  read word; valid with `bus_ack`.

## Operation
- Reset values: state IDLE, counter 0, `bus_req`/`bus_we`/`rdata_valid` 0, `bus_addr`/`bus_be`/`bus_wdata`/`rdata` 0.
- Access = `mem_read | mem_write`. Read has priority: if both are set, the access is a load.
- Alignment: half (LH/LHU/SH) requires `addr[0]`=0; word (LW/SW) requires `addr[1:0]`=0.
- Illegal type: load_type 011/110/111, or store_type other than 000/001/010. Raises `access_fault` combinationally in IDLE; no bus traffic; no stall.
- Misaligned access in IDLE: `misalign`=1 that cycle; no bus traffic; `stall`=0.
- FSM:
  - IDLE: on a legal, aligned access with `flush`=0, latch the bus signals and go to BUSY. `stall`=1.
  - BUSY: `bus_req` held. The counter increments each cycle without ack. On `bus_ack`, capture the formatted `bus_rdata`, drop `bus_req` and go to RESP. If the counter reaches TIMEOUT-1 with no ack, drop `bus_req`, set `rdata`=0 and a fault flag, and go to RESP. `stall`=1.
  - RESP: `stall`=0. For a load, `rdata_valid`=1. A timed-out access gives `access_fault`=1 instead. Inputs are ignored. Next state is IDLE.
- Byte enables:
  - SB/LB/LBU: `1<<addr[1:0]`.
  - SH/LH/LHU: 0011 if `addr[1]`=0, else 1100.
  - SW/LW: 1111.
- Store data: SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`.
- Load data: select the lane by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend.
- `flush` in BUSY: the bus transaction still completes (no abandon). RESP then suppresses `rdata_valid` and `access_fault`.
- `rst_n` low at any time forces reset values immediately, including dropping `bus_req` mid-transaction.

## Timing
- Access presented in cycle N (IDLE): `bus_req` is high from N+1.
- `bus_ack` in cycle M ≥ N+1: RESP in M+1 with `rdata`/`rdata_valid`. `bus_req` is low in M+1.
- Zero-wait slave: `stall` is high in N and N+1 and low in N+2. The access occupies 3 cycles.
- Timeout: with no ack, RESP falls at N+1+TIMEOUT.
- `bus_ack` outside BUSY is ignored.
- Back-to-back accesses: the next instruction's access is first seen in the IDLE cycle after RESP.

## Test plan
- LB at 0x1003, `bus_rdata`=0x80FF_0000, ack on the first BUSY cycle: `bus_be`=1000, `bus_addr`=0x1000; RESP `rdata`=0xFFFF_FF80; `stall` high for exactly 2 cycles.
- LHU at 0x2002, `bus_rdata`=0xBEEF_1234, ack after 3 wait cycles: `rdata`=0x0000_BEEF, `rdata_valid` high for one cycle.
- SB at 0x3001 with `wdata`=0x1234_56AB: `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xABAB_ABAB; SW at 0x3002: `misalign`=1, `bus_req` never rises, `stall`=0.
- TIMEOUT=4, LW with no ack: `bus_req` high for 4 cycles; RESP `access_fault`=1, `rdata`=0, `rdata_valid`=0; then IDLE.
- LW, `flush` asserted in BUSY, ack 2 cycles later: the transaction completes, `rdata_valid` stays 0. Load with load_type=011: `access_fault`=1, no request.
- `rst_n` pulled low mid-BUSY: `bus_req`, `stall` and state clear immediately. After release, a new SW proceeds normally.

Source files
------------

// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Purpose  : MEM-stage load/store unit. Decodes the decoder's memory control
//            fields, runs one request/acknowledge transaction on the data
//            bus with byte-lane steering, formats load data (sign/zero
//            extension), aborts on a bus timeout and stalls the pipeline
//            while an access is in flight.
// Ports    : clk_i, rst_n_i            clock / async active-low reset
//            mem_read_i, load_type_i   load request and funct3
//            mem_write_i, store_type_i store request and funct3
//            addr_i, wdata_i           effective address, store data (rs2)
//            flush_i                   squash current MEM instruction
//            stall_o                   pipeline hold (combinational)
//            rdata_o, rdata_valid_o    formatted load result (registered)
//            misalign_o                misaligned access (combinational)
//            access_fault_o            illegal type or bus timeout
//            bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
//                                      registered bus request side
//            bus_ack_i, bus_rdata_i    bus completion and read word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_read_i,
    input  logic [2:0]  load_type_i,
    input  logic        mem_write_i,
    input  logic [2:0]  store_type_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        access_fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Access size encoding
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          fault_q, fault_d;
    logic          flush_q, flush_d;
    logic          is_load_q, is_load_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_access;
    logic        w_legal;
    logic [1:0]  w_size;
    logic        w_unsigned;
    logic        w_aligned;
    logic        w_idle;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_access = mem_read_i | mem_write_i;

    // A load wins when both MemRead and MemWrite are set.
    always_comb begin
        w_legal    = 1'b1;
        w_size     = SZ_WORD;
        w_unsigned = 1'b0;
        if (mem_read_i) begin
            case (load_type_i)
                3'b000:  w_size = SZ_BYTE;
                3'b001:  w_size = SZ_HALF;
                3'b010:  w_size = SZ_WORD;
                3'b100: begin
                    w_size     = SZ_BYTE;
                    w_unsigned = 1'b1;
                end
                3'b101: begin
                    w_size     = SZ_HALF;
                    w_unsigned = 1'b1;
                end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (store_type_i)
                3'b000:  w_size = SZ_BYTE;
                3'b001:  w_size = SZ_HALF;
                3'b010:  w_size = SZ_WORD;
                default: w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (w_size)
            SZ_BYTE: w_aligned = 1'b1;
            SZ_HALF: w_aligned = ~addr_i[0];
            default: w_aligned = (addr_i[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata_i;
            end
        endcase
    end

    assign w_idle  = (state_q == IDLE);
    assign w_start = w_idle & w_access & w_legal & w_aligned & ~flush_i;

    // ------------------------------------------------------------------
    // Load data formatting from the lane captured at request time
    // ------------------------------------------------------------------
    logic [31:0] w_shifted;
    logic [31:0] w_fmt;

    assign w_shifted = bus_rdata_i >> {addr_lo_q, 3'b000};

    always_comb begin
        case (size_q)
            SZ_BYTE: w_fmt = {{24{w_shifted[7] & ~unsigned_q}}, w_shifted[7:0]};
            SZ_HALF: w_fmt = {{16{w_shifted[15] & ~unsigned_q}}, w_shifted[15:0]};
            default: w_fmt = bus_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        fault_d       = 1'b0;
        flush_d       = flush_q;
        is_load_d     = is_load_q;
        addr_lo_d     = addr_lo_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    bus_req_d  = 1'b1;
                    bus_we_d   = ~mem_read_i;
                    bus_addr_d = {addr_i[31:2], 2'b00};
                    bus_be_d   = w_be;
                    if (!mem_read_i) begin
                        bus_wdata_d = w_wdata;
                    end
                    flush_d    = 1'b0;
                    is_load_d  = mem_read_i;
                    addr_lo_d  = addr_i[1:0];
                    size_d     = w_size;
                    unsigned_d = w_unsigned;
                end
            end

            BUSY: begin
                // A flush never abandons the bus cycle; it only silences RESP.
                if (flush_i) begin
                    flush_d = 1'b1;
                end
                if (bus_ack_i) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (is_load_q) begin
                        rdata_d = w_fmt;
                    end
                    rdata_valid_d = is_load_q & ~flush_q & ~flush_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    rdata_d   = '0;
                    fault_d   = ~flush_q & ~flush_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            flush_q       <= 1'b0;
            is_load_q     <= 1'b0;
            addr_lo_q     <= '0;
            size_q        <= SZ_BYTE;
            unsigned_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            fault_q       <= fault_d;
            flush_q       <= flush_d;
            is_load_q     <= is_load_d;
            addr_lo_q     <= addr_lo_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_o        = w_start | (state_q == BUSY);
    assign misalign_o     = w_idle & w_access & w_legal & ~w_aligned;
    // fault_q is only ever high during the RESP cycle of a timed-out access.
    assign access_fault_o = (w_idle & w_access & ~w_legal) | fault_q;
    assign rdata_o        = rdata_q;
    assign rdata_valid_o  = rdata_valid_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_be_o       = bus_be_q;
    assign bus_wdata_o    = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none

module tb_mem_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic [2:0]  load_type = 3'b000;
    logic        mem_write = 1'b0;
    logic [2:0]  store_type = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .mem_read_i     (mem_read),
        .load_type_i    (load_type),
        .mem_write_i    (mem_write),
        .store_type_i   (store_type),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .flush_i        (flush),
        .stall_o        (stall),
        .rdata_o        (rdata),
        .rdata_valid_o  (rdata_valid),
        .misalign_o     (misalign),
        .access_fault_o (access_fault),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_be_o       (bus_be),
        .bus_wdata_o    (bus_wdata),
        .bus_ack_i      (bus_ack),
        .bus_rdata_i    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: returns access width in bytes (0 = illegal type).
    function automatic int nbytes_of(input bit ld, input logic [2:0] t, output bit sgn);
        sgn = 1'b0;
        if (ld) begin
            case (t)
                3'd0: begin nbytes_of = 1; sgn = 1'b1; end
                3'd1: begin nbytes_of = 2; sgn = 1'b1; end
                3'd2: nbytes_of = 4;
                3'd4: nbytes_of = 1;
                3'd5: nbytes_of = 2;
                default: nbytes_of = 0;
            endcase
        end else begin
            case (t)
                3'd0: nbytes_of = 1;
                3'd1: nbytes_of = 2;
                3'd2: nbytes_of = 4;
                default: nbytes_of = 0;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input int nb, input bit sgn);
        longint unsigned v;
        v = (longint'(word) >> (8 * (a % 4))) & ((64'h1 << (8 * nb)) - 1);
        if (sgn && nb < 4 && v >= (64'h1 << (8 * nb - 1)))
            v = v + 64'h1_0000_0000 - (64'h1 << (8 * nb));
        model_load = v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int nb);
        if (nb == 1)      model_wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (nb == 2) model_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else              model_wdata = wd;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input int nb);
        int m;
        m = ((1 << nb) - 1) << (a % 4);
        model_be = m[3:0];
    endfunction

    task automatic idle_inputs();
        mem_read = 1'b0;
        mem_write = 1'b0;
        flush = 1'b0;
        bus_ack = 1'b0;
    endtask

    // One MEM-stage instruction from presentation to the IDLE cycle after it.
    // delay >= TO means the slave never acknowledges.
    task automatic run_access(input bit ld, input logic [2:0] ty, input logic [31:0] a,
                              input logic [31:0] wd, input int delay,
                              input logic [31:0] rword, input bit fl);
        bit sgn;
        int nb;
        bit timed_out;
        bit done;
        logic [31:0] exp_rd;
        nb = nbytes_of(ld, ty, sgn);
        mem_read = ld;
        mem_write = ~ld;
        load_type = ty;
        store_type = ty;
        addr = a;
        wdata = wd;
        #1;
        if (nb == 0) begin
            chk("illegal_fault", access_fault, 1);
            chk("illegal_stall", stall, 0);
            tick();
            idle_inputs();
            chk("illegal_noreq", bus_req, 0);
            return;
        end
        if ((a % nb) != 0) begin
            chk("misalign_flag", misalign, 1);
            chk("misalign_stall", stall, 0);
            chk("misalign_fault", access_fault, 0);
            tick();
            idle_inputs();
            chk("misalign_noreq", bus_req, 0);
            return;
        end
        chk("start_stall", stall, 1);
        chk("start_misalign", misalign, 0);
        tick();
        idle_inputs();
        chk("busy_req", bus_req, 1);
        chk("busy_we", bus_we, !ld);
        chk("busy_addr", bus_addr, a & 32'hFFFF_FFFC);
        chk("busy_be", bus_be, model_be(a, nb));
        if (!ld) chk("busy_wdata", bus_wdata, model_wdata(wd, nb));
        timed_out = (delay >= TO);
        exp_rd = model_load(rword, a, nb, sgn);
        for (int c = 0; c < TO; c++) begin
            chk("busy_stall", stall, 1);
            if (c > 0) chk("busy_req_hold", bus_req, 1);
            flush = fl && (c == 0);
            done = (c == delay) || (c == TO - 1);
            if (c == delay) begin
                bus_ack = 1'b1;
                bus_rdata = rword;
            end
            tick();
            flush = 1'b0;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (done) break;
        end
        chk("resp_stall", stall, 0);
        chk("resp_req", bus_req, 0);
        chk("resp_valid", rdata_valid, ld && !timed_out && !fl);
        chk("resp_fault", access_fault, timed_out && !fl);
        if (timed_out) chk("resp_rdata_to", rdata, 0);
        else if (ld && !fl) chk("resp_rdata", rdata, exp_rd);
        bus_ack = 1'b1;  // stray ack outside BUSY must be ignored
        tick();
        bus_ack = 1'b0;
        chk("idle_valid", rdata_valid, 0);
        chk("idle_fault", access_fault, 0);
        chk("idle_req", bus_req, 0);
        chk("idle_stall", stall, 0);
    endtask

    initial begin
        #12;
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;
        tick();

        // LB 0x1003, zero-wait slave
        run_access(1'b1, 3'b000, 32'h1003, 32'h0, 0, 32'h80FF_0000, 1'b0);
        chk("lb_rdata_const", rdata, 32'hFFFF_FF80);
        // LHU 0x2002, three wait cycles
        run_access(1'b1, 3'b101, 32'h2002, 32'h0, 3, 32'hBEEF_1234, 1'b0);
        chk("lhu_rdata_const", rdata, 32'h0000_BEEF);
        // SB 0x3001, then misaligned SW
        run_access(1'b0, 3'b000, 32'h3001, 32'h1234_56AB, 0, 32'h0, 1'b0);
        chk("sb_wdata_const", bus_wdata, 32'hABAB_ABAB);
        run_access(1'b0, 3'b010, 32'h3002, 32'h1, 0, 32'h0, 1'b0);
        // LW with no acknowledge
        run_access(1'b1, 3'b010, 32'h4000, 32'h0, 99, 32'h0, 1'b0);
        // LW flushed while BUSY, ack two cycles later
        run_access(1'b1, 3'b010, 32'h5000, 32'h0, 2, 32'h1357_9BDF, 1'b1);
        // Illegal load type
        run_access(1'b1, 3'b011, 32'h6000, 32'h0, 0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of a BUSY cycle
        mem_read = 1'b1;
        load_type = 3'b010;
        addr = 32'h7000;
        tick();
        idle_inputs();
        chk("pre_rst_req", bus_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", bus_req, 0);
        chk("async_rst_stall", stall, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", bus_req, 0);
        run_access(1'b0, 3'b010, 32'h8004, 32'hCAFE_F00D, 1, 32'h0, 1'b0);

        // Randomized accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            bit ld;
            logic [2:0] ty;
            ld = $urandom_range(0, 1);
            ty = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
               : (ld ? 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2))
                     : 3'($urandom_range(0, 2)));
            run_access(ld, ty, $urandom, $urandom, int'($urandom_range(0, 5)),
                       $urandom, ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
